// File: rtl/vidout_capture.sv
`default_nettype none
// ============================================================================
// vidout_capture: classifies raw video DAC samples into sync/level codes,
//                 frames active lines and queues tagged samples in a FIFO.
// Rev 1.0
// ============================================================================
module vidout_capture #(
   parameter int SYNC_MIN   = 8,
   parameter int VSYNC_MIN  = 64,
   parameter int H_SKIP     = 16,
   parameter int H_ACTIVE   = 256,
   parameter int V_SKIP     = 20,
   parameter int V_ACTIVE   = 240,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        CLK,
   input  logic        n_RES,
   input  logic        SAMPLE_EN,
   input  logic [10:0] RawVOut,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  out_data,
   output logic        overflow,
   output logic [8:0]  line_cnt,
   output logic [7:0]  frame_cnt
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int SKW = $clog2(H_SKIP + 1);
   localparam int PXW = $clog2(H_ACTIVE + 1);

   typedef enum logic [1:0] {
      BLANK  = 2'd0,
      SYNC   = 2'd1,
      SKIP   = 2'd2,
      ACTIVE = 2'd3
   } state_t;

   state_t           state_q;
   logic [7:0]       run_len_q;
   logic [SKW-1:0]   skip_cnt_q;
   logic [PXW-1:0]   pix_cnt_q;
   logic [8:0]       line_cnt_q;
   logic [7:0]       frame_cnt_q;
   logic             pend_sof_q;

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic [5:0]       mem_q [FIFO_DEPTH];

   logic [3:0]       lvl;
   logic [7:0]       run_len_next;
   logic             sync_hit;
   logic             is_vsync;
   logic             line_in_window;
   logic             push_req;
   logic [5:0]       push_word;
   logic             fifo_empty;
   logic             fifo_full;
   logic             do_push;
   logic             do_pop;

   // Level code is 1 + index of the highest set bit; all-zero is the sync tip.
   function automatic logic [3:0] level_of(input logic [10:0] v);
      logic [3:0] l;
      l = 4'd0;
      for (int i = 0; i < 11; i++) begin
         if (v[i]) begin
            l = 4'(i + 1);
         end
      end
      return l;
   endfunction

   assign lvl            = level_of(RawVOut);
   assign run_len_next   = (lvl != 4'd0) ? 8'd0 :
                           (run_len_q == 8'hFF) ? 8'hFF : run_len_q + 8'd1;
   assign sync_hit       = (lvl == 4'd0) && ((int'(run_len_q) + 1) == SYNC_MIN);
   assign is_vsync       = int'(run_len_q) >= VSYNC_MIN;
   assign line_in_window = (int'(line_cnt_q) >= V_SKIP) &&
                           (int'(line_cnt_q) <= V_SKIP + V_ACTIVE - 1);

   // The sample that completes a sync run belongs to the sync, never to the line.
   assign push_req  = SAMPLE_EN && (state_q == ACTIVE) && !sync_hit;
   assign push_word = {pend_sof_q, (pix_cnt_q == '0), lvl};

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         state_q     <= BLANK;
         run_len_q   <= 8'd0;
         skip_cnt_q  <= '0;
         pix_cnt_q   <= '0;
         line_cnt_q  <= 9'd0;
         frame_cnt_q <= 8'd0;
         pend_sof_q  <= 1'b0;
      end else if (SAMPLE_EN) begin
         run_len_q <= run_len_next;
         case (state_q)
            BLANK: begin
               if (sync_hit) begin
                  state_q <= SYNC;
               end
            end
            SYNC: begin
               if (lvl != 4'd0) begin
                  // The sync-ending sample is the first of the skipped samples.
                  state_q    <= SKIP;
                  skip_cnt_q <= SKW'(1);
                  if (is_vsync) begin
                     line_cnt_q  <= 9'd0;
                     frame_cnt_q <= frame_cnt_q + 8'd1;
                     pend_sof_q  <= 1'b1;
                  end else if (line_cnt_q != 9'd511) begin
                     line_cnt_q <= line_cnt_q + 9'd1;
                  end
               end
            end
            SKIP: begin
               if (sync_hit) begin
                  state_q <= SYNC;
               end else if ((int'(skip_cnt_q) + 1) >= H_SKIP) begin
                  state_q   <= line_in_window ? ACTIVE : BLANK;
                  pix_cnt_q <= '0;
               end else begin
                  skip_cnt_q <= skip_cnt_q + 1'b1;
               end
            end
            ACTIVE: begin
               if (sync_hit) begin
                  state_q <= SYNC;
               end else begin
                  pix_cnt_q  <= pix_cnt_q + 1'b1;
                  pend_sof_q <= 1'b0;
                  if ((int'(pix_cnt_q) + 1) == H_ACTIVE) begin
                     state_q <= BLANK;
                  end
               end
            end
            default: state_q <= BLANK;
         endcase
      end
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop     = !fifo_empty && out_ready;
   assign do_push    = push_req && (!fifo_full || do_pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_req && fifo_full && !do_pop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: clearing the pointers discards its contents.
   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_word;
      end
   end

   assign out_valid = !fifo_empty;
   assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
   assign overflow  = overflow_q;
   assign line_cnt  = line_cnt_q;
   assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vidout_capture.sv
`default_nettype none
// Testbench for vidout_capture: randomized sample streams compared against a
// line/frame-level behavioural model and a queue-based FIFO model.
module tb_vidout_capture;

   localparam int SYNC_MIN   = 8;
   localparam int VSYNC_MIN  = 64;
   localparam int H_SKIP     = 16;
   localparam int H_ACTIVE   = 256;
   localparam int V_SKIP     = 20;
   localparam int V_ACTIVE   = 240;
   localparam int FIFO_DEPTH = 16;

   logic        CLK = 1'b0;
   logic        n_RES;
   logic        SAMPLE_EN;
   logic [10:0] RawVOut;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_data;
   logic        overflow;
   logic [8:0]  line_cnt;
   logic [7:0]  frame_cnt;

   vidout_capture #(
      .SYNC_MIN  (SYNC_MIN),
      .VSYNC_MIN (VSYNC_MIN),
      .H_SKIP    (H_SKIP),
      .H_ACTIVE  (H_ACTIVE),
      .V_SKIP    (V_SKIP),
      .V_ACTIVE  (V_ACTIVE),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .CLK      (CLK),
      .n_RES    (n_RES),
      .SAMPLE_EN(SAMPLE_EN),
      .RawVOut  (RawVOut),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .overflow (overflow),
      .line_cnt (line_cnt),
      .frame_cnt(frame_cnt)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;
   int rdy_mode = 1;   // 0: never ready, 1: always ready, 2: random

   // Model state: sync run, position within the line, line/frame bookkeeping.
   int   m_run, m_since, m_line, m_frame;
   bit   m_in_sync, m_pend, m_elig, m_ovf;
   logic [5:0] mq[$];
   logic [5:0] exp_q[$];
   logic [5:0] got_q[$];

   function automatic int lvl_of(input logic [10:0] raw);
      if (raw == 11'd0) return 0;
      return $clog2(int'(raw) + 1);
   endfunction

   task automatic model_reset();
      m_run = 0; m_since = 0; m_line = 0; m_frame = 0;
      m_in_sync = 0; m_pend = 0; m_elig = 0; m_ovf = 0;
      mq.delete();
   endtask

   task automatic model_sample(input int lvl, output bit push, output logic [5:0] word);
      bit hit;
      hit  = (lvl == 0) && (m_run + 1 == SYNC_MIN);
      push = 0;
      word = 6'd0;
      if (m_in_sync) begin
         if (lvl != 0) begin
            m_in_sync = 0;
            m_since   = 1;
            if (m_run >= VSYNC_MIN) begin
               m_line  = 0;
               m_frame = (m_frame + 1) % 256;
               m_pend  = 1;
            end else begin
               m_line = (m_line < 511) ? m_line + 1 : 511;
            end
            m_elig = (m_line >= V_SKIP) && (m_line < V_SKIP + V_ACTIVE);
         end
      end else if (hit) begin
         m_in_sync = 1;
         m_since   = 0;
      end else if (m_since > 0) begin
         if (m_since < H_SKIP) begin
            m_since++;
         end else if (m_elig && m_since < H_SKIP + H_ACTIVE) begin
            push   = 1;
            word   = {m_pend, (m_since == H_SKIP), 4'(lvl)};
            m_pend = 0;
            m_since++;
         end else begin
            m_since = 0;
         end
      end
      m_run = (lvl == 0) ? ((m_run < 255) ? m_run + 1 : 255) : 0;
   endtask

   // Drives one clock of inputs at a falling edge, records DUT pops, advances the model.
   task automatic cyc(input bit en, input logic [10:0] raw);
      bit push, pop, full;
      logic [5:0] w;
      SAMPLE_EN = en;
      RawVOut   = raw;
      out_ready = (rdy_mode == 2) ? 1'($urandom % 2) : (rdy_mode == 1);
      if (out_valid && out_ready) got_q.push_back(out_data);
      pop  = out_ready && (mq.size() > 0);
      full = (mq.size() == FIFO_DEPTH);
      push = 0;
      w    = 6'd0;
      if (en) model_sample(lvl_of(raw), push, w);
      if (pop) exp_q.push_back(mq.pop_front());
      if (push) begin
         if (!full || pop) mq.push_back(w);
         else m_ovf = 1;
      end
      @(negedge CLK);
   endtask

   task automatic smp(input logic [10:0] raw);
      repeat ($urandom_range(0, 1)) cyc(1'b0, 11'($urandom));
      cyc(1'b1, raw);
   endtask

   task automatic feed_zero(input int n);
      repeat (n) smp(11'd0);
   endtask

   task automatic feed_nz(input int n);
      repeat (n) smp(11'($urandom_range(1, 2047)));
   endtask

   task automatic feed_val(input int n, input logic [10:0] v);
      repeat (n) smp(v);
   endtask

   task automatic feed_mix(input int n);
      repeat (n) smp(($urandom % 8 == 0) ? 11'd0 : 11'($urandom_range(1, 2047)));
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 11'($urandom));
   endtask

   task automatic do_reset();
      SAMPLE_EN = 1'b0;
      n_RES     = 1'b0;
      repeat (2) @(negedge CLK);
      n_RES = 1'b1;
      model_reset();
      got_q.delete();
      exp_q.delete();
   endtask

   // Vertical sync followed by 20 short hsyncs; the next non-zero sample ends line 20's sync.
   task automatic frame_prefix();
      feed_zero(70);
      repeat (20) begin
         feed_nz(6);
         feed_zero(10);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: out_valid=%b expected 0", out_valid); end
      n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: overflow=%b expected 0", overflow); end
      n_checks++; if (line_cnt !== 9'd0) begin n_errors++; $display("FAIL reset_line: line_cnt=%0d expected 0", line_cnt); end
      n_checks++; if (frame_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_frame: frame_cnt=%0d expected 0", frame_cnt); end
   endtask

   task automatic test_vsync_only();
      do_reset();
      rdy_mode = 1;
      feed_zero(70);
      feed_nz(16);
      idle(4);
      n_checks++; if (frame_cnt !== 8'd1) begin n_errors++; $display("FAIL vsync_frame: frame_cnt=%0d expected 1", frame_cnt); end
      n_checks++; if (line_cnt !== 9'd0) begin n_errors++; $display("FAIL vsync_line: line_cnt=%0d expected 0", line_cnt); end
      n_checks++; if (got_q.size() != 0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL vsync_nopush: words=%0d out_valid=%b expected 0/0", got_q.size(), out_valid); end
      n_checks++; if (frame_cnt !== 8'(m_frame)) begin n_errors++; $display("FAIL vsync_model: frame_cnt=%0d model %0d", frame_cnt, m_frame); end
   endtask

   task automatic test_sync_boundaries();
      do_reset();
      rdy_mode = 1;
      feed_zero(SYNC_MIN - 1); feed_nz(1);
      feed_zero(SYNC_MIN - 1); feed_nz(20);
      n_checks++; if (line_cnt !== 9'd0) begin n_errors++; $display("FAIL short_run: line_cnt=%0d expected 0", line_cnt); end
      feed_zero(SYNC_MIN); feed_nz(20);
      n_checks++; if (line_cnt !== 9'd1) begin n_errors++; $display("FAIL exact_hsync: line_cnt=%0d expected 1", line_cnt); end
      feed_zero(VSYNC_MIN - 1); feed_nz(20);
      n_checks++; if (line_cnt !== 9'd2 || frame_cnt !== 8'd0) begin n_errors++; $display("FAIL long_hsync: line=%0d frame=%0d expected 2/0", line_cnt, frame_cnt); end
      feed_zero(VSYNC_MIN); feed_nz(20);
      n_checks++; if (line_cnt !== 9'd0 || frame_cnt !== 8'd1) begin n_errors++; $display("FAIL exact_vsync: line=%0d frame=%0d expected 0/1", line_cnt, frame_cnt); end
   endtask

   task automatic test_active_line();
      int bad;
      do_reset();
      rdy_mode = 1;
      frame_prefix();
      feed_nz(H_SKIP);
      feed_val(H_ACTIVE, 11'h010);
      feed_nz(8);
      idle(30);
      n_checks++; if (got_q.size() != 256) begin n_errors++; $display("FAIL line_count: words=%0d expected 256", got_q.size()); end
      n_checks++; if (got_q.size() > 0 && got_q[0] !== 6'b110101) begin n_errors++; $display("FAIL line_first: word=%b expected 110101", got_q[0]); end
      bad = 0;
      for (int i = 1; i < got_q.size(); i++) if (got_q[i] !== 6'b000101) bad++;
      n_checks++; if (bad != 0) begin n_errors++; $display("FAIL line_rest: %0d words differ from 000101, expected 0", bad); end
      n_checks++; if (line_cnt !== 9'd20 || frame_cnt !== 8'd1) begin n_errors++; $display("FAIL line_cnts: line=%0d frame=%0d expected 20/1", line_cnt, frame_cnt); end
      n_checks++; if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL line_model_len: words=%0d model %0d", got_q.size(), exp_q.size()); end
   endtask

   task automatic test_overflow();
      do_reset();
      rdy_mode = 0;
      frame_prefix();
      feed_nz(H_SKIP);
      feed_val(FIFO_DEPTH, 11'h010);
      n_checks++; if (overflow !== 1'b0 || out_valid !== 1'b1) begin n_errors++; $display("FAIL ovf_at_full: overflow=%b valid=%b expected 0/1", overflow, out_valid); end
      feed_val(1, 11'h010);
      n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set: overflow=%b expected 1", overflow); end
      feed_val(H_ACTIVE - FIFO_DEPTH - 1, 11'h010);
      idle(10);
      n_checks++; if (out_data !== 6'b110101) begin n_errors++; $display("FAIL ovf_hold: out_data=%b expected 110101", out_data); end
      n_checks++; if (overflow !== 1'b1 || mq.size() != FIFO_DEPTH) begin n_errors++; $display("FAIL ovf_sticky: overflow=%b model_fill=%0d expected 1/16", overflow, mq.size()); end
      rdy_mode = 1;
      idle(FIFO_DEPTH + 8);
      n_checks++; if (got_q.size() != FIFO_DEPTH) begin n_errors++; $display("FAIL ovf_drain: words=%0d expected 16", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL ovf_word[%0d]: got %b expected %b", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_abort();
      int sols;
      do_reset();
      rdy_mode = 1;
      frame_prefix();
      feed_nz(H_SKIP);
      feed_nz(100);
      feed_zero(12);
      n_checks++; if (line_cnt !== 9'd20) begin n_errors++; $display("FAIL abort_sync: line_cnt=%0d expected 20", line_cnt); end
      feed_nz(H_SKIP);
      n_checks++; if (line_cnt !== 9'd21) begin n_errors++; $display("FAIL abort_line: line_cnt=%0d expected 21", line_cnt); end
      feed_nz(H_ACTIVE + 4);
      idle(30);
      n_checks++; if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL abort_len: words=%0d model %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL abort_word[%0d]: got %b expected %b", i, got_q[i], exp_q[i]); end
      end
      sols = 0;
      foreach (got_q[i]) if (got_q[i][4]) sols++;
      n_checks++; if (sols != 2) begin n_errors++; $display("FAIL abort_sols: SOL words=%0d expected 2", sols); end
      n_checks++; if (got_q.size() >= 256 && got_q[got_q.size() - 256][5:4] !== 2'b01) begin n_errors++; $display("FAIL abort_next_sol: sof/sol=%b expected 01", got_q[got_q.size() - 256][5:4]); end
   endtask

   task automatic test_async_reset();
      do_reset();
      rdy_mode = 0;
      frame_prefix();
      feed_nz(H_SKIP);
      feed_nz(40);
      SAMPLE_EN = 1'b0;
      n_checks++; if (overflow !== 1'b1 || out_valid !== 1'b1 || frame_cnt !== 8'd1) begin n_errors++; $display("FAIL pre_reset: ovf=%b valid=%b frame=%0d expected 1/1/1", overflow, out_valid, frame_cnt); end
      #2 n_RES = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL areset_valid: out_valid=%b expected 0", out_valid); end
      n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL areset_ovf: overflow=%b expected 0", overflow); end
      n_checks++; if (frame_cnt !== 8'd0 || line_cnt !== 9'd0) begin n_errors++; $display("FAIL areset_cnts: frame=%0d line=%0d expected 0/0", frame_cnt, line_cnt); end
      n_RES = 1'b1;
      model_reset();
      got_q.delete();
      exp_q.delete();
      @(negedge CLK);
      rdy_mode = 1;
      feed_nz(40);
      n_checks++; if (out_valid !== 1'b0 || got_q.size() != 0) begin n_errors++; $display("FAIL after_reset: valid=%b words=%0d expected 0/0", out_valid, got_q.size()); end
   endtask

   task automatic test_random();
      do_reset();
      rdy_mode = 2;
      frame_prefix();
      repeat (3) begin
         feed_nz(H_SKIP);
         feed_mix(H_ACTIVE + 4);
         feed_zero(SYNC_MIN + $urandom_range(0, 4));
      end
      feed_nz(H_SKIP);
      feed_mix(100);
      rdy_mode = 1;
      idle(40);
      n_checks++; if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rand_len: words=%0d model %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rand_word[%0d]: got %b expected %b", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (overflow !== m_ovf) begin n_errors++; $display("FAIL rand_ovf: overflow=%b model %b", overflow, m_ovf); end
      n_checks++; if (line_cnt !== 9'(m_line) || frame_cnt !== 8'(m_frame)) begin n_errors++; $display("FAIL rand_cnts: line=%0d frame=%0d model %0d/%0d", line_cnt, frame_cnt, m_line, m_frame); end
      n_checks++; if (out_valid !== (mq.size() != 0)) begin n_errors++; $display("FAIL rand_valid: out_valid=%b model fill %0d", out_valid, mq.size()); end
   endtask

   initial begin
      n_RES     = 1'b0;
      SAMPLE_EN = 1'b0;
      RawVOut   = 11'd0;
      out_ready = 1'b0;
      test_reset();
      test_vsync_only();
      test_sync_boundaries();
      test_active_line();
      test_overflow();
      test_abort();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vidout_capture.md
VIDOUT_CAPTURE -- requirements
Module: vidout_capture

Interface
REQ-001 Parameters SHALL be:
- SYNC_MIN, default 8, minimum run of sync-tip samples counted as a sync pulse.
- VSYNC_MIN, default 64, minimum sync run classified as vertical sync.
- H_SKIP, default 16, samples skipped after sync end before capture.
- H_ACTIVE, default 256, samples captured per line.
- V_SKIP, default 20, lines skipped after vertical sync.
- V_ACTIVE, default 240, lines captured per frame.
- FIFO_DEPTH, default 16, output FIFO entries (power of 2).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, sole clock; all state on rising edge.
- n_RES, in, 1, asynchronous active-low reset.
- SAMPLE_EN, in, 1, one-CLK strobe; RawVOut is sampled only when high.
- RawVOut, in, 11, raw DAC level-select vector from the video generator.
- out_valid, out, 1, FIFO head is valid.
- out_ready, in, 1, consumer accepts head.
- out_data, out, 6, [5] SOF, [4] SOL, [3:0] level code.
- overflow, out, 1, sticky: a sample was dropped on a full FIFO.
- line_cnt, out, 9, current line since last vertical sync.
- frame_cnt, out, 8, completed vertical syncs.

Function
REQ-003 Level code SHALL be 0 when RawVOut is all zero (sync tip), else 1 + index of the highest set bit (1..11).
REQ-004 All state except the FIFO pop and the n_RES response SHALL advance only on cycles with SAMPLE_EN=1.
REQ-005 The FSM SHALL have states BLANK, SYNC, SKIP, ACTIVE, with BLANK after reset.
REQ-006 Every sample SHALL update run_len: run_len increments on a level-0 sample, saturating at 255, and clears to 0 on a non-zero sample.
REQ-007 BLANK->SYNC SHALL occur on the sample where run_len reaches SYNC_MIN; SKIP or ACTIVE SHALL also go to SYNC at that point, aborting the current line without flushing the FIFO.
REQ-008 SYNC->SKIP SHALL occur on the first non-zero sample; a run length >= VSYNC_MIN SHALL:
- clear line_cnt;
- increment frame_cnt, wrapping at 255;
- set a pending-SOF flag.
A shorter run SHALL increment line_cnt, saturating at 511.
REQ-009 SKIP SHALL count H_SKIP samples, then enter ACTIVE if line_cnt is in [V_SKIP, V_SKIP+V_ACTIVE-1]; otherwise it SHALL enter BLANK.
REQ-010 ACTIVE SHALL push exactly H_ACTIVE samples and then enter BLANK.
- The first push of a line SHALL set SOL.
- The first push after pending-SOF SHALL set SOF and clear pending-SOF.
REQ-011 Push latency: a sample taken on edge N SHALL be visible at out_data no earlier than edge N+1; the FIFO has no same-cycle bypass.
REQ-012 The FIFO SHALL pop when out_valid and out_ready are both 1.
- Full with push and pop in the same cycle: the push is accepted.
- Full with push only: the sample is dropped, overflow is set, and it stays set until reset.
- Empty with push and pop in the same cycle: the pop is ignored.
REQ-013 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-014 Pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit distinguishing full from empty.

Reset
REQ-015 n_RES low SHALL immediately force the following, independent of CLK:
- FSM to BLANK;
- run_len, skip/pixel counters, line_cnt, frame_cnt and FIFO pointers to 0;
- out_valid=0, overflow=0, pending-SOF=0.
REQ-016 Reset asserted mid-line SHALL discard FIFO contents.
REQ-017 Release SHALL be honoured on the first CLK edge after n_RES rises.

Verification
REQ-018 Input 70 zero samples, then 16 non-zero -> frame_cnt=1, line_cnt=0, FSM reaches BLANK, no pushes (V_SKIP=20).
REQ-019 Vertical sync, then 20 lines of 10-sample hsync, then 16 skip samples and 256 samples of RawVOut=11'h010 with out_ready=1:
- 256 words of level 5;
- first word has SOF=1, SOL=1;
- remaining words have SOF=0, SOL=0.
REQ-020 Same stimulus with out_ready=0 -> exactly 16 words held, overflow=1 after the 17th push, first word unchanged.
REQ-021 12 zero samples injected after 100 active samples -> line aborted, FSM=SYNC, line_cnt increments, next line's first word has SOL=1.
REQ-022 n_RES pulsed low for 1 ns mid-ACTIVE between CLK edges -> out_valid=0, overflow=0, frame_cnt=0 immediately.
REQ-023 7 zero samples then a non-zero sample -> no SYNC entry, run_len=0.
